// File: rtl/pi_duty_controller_pkg.sv
// pi_duty_controller_pkg: shared limits, widths and FSM state codes for the PI regulator and PWM stage
package pi_duty_controller_pkg;
  localparam int FRAC_BITS = 8;
  localparam int ACC_W = 32;
  localparam int DUTY_W = 12;
  localparam int OUT_MAX = 670;
  localparam int OUT_MIN = -780;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CAPTURE = 3'd1;
  localparam logic [2:0] S_MUL_P = 3'd2;
  localparam logic [2:0] S_MUL_I = 3'd3;
  localparam logic [2:0] S_SUM = 3'd4;
  localparam logic [2:0] S_SAT = 3'd5;
endpackage

// File: rtl/pi_duty_controller_sat_clamp.sv
// pi_duty_controller_sat_clamp: signed saturate i_val to [i_lo,i_hi]; o_val result, o_clamped high when limited
module pi_duty_controller_sat_clamp
  import pi_duty_controller_pkg::*;
#(
  parameter int W = ACC_W
) (
  input  logic signed [W-1:0] i_val,
  input  logic signed [W-1:0] i_lo,
  input  logic signed [W-1:0] i_hi,
  output logic signed [W-1:0] o_val,
  output logic                o_clamped
);
  always_comb begin
    o_val = i_val > i_hi ? i_hi : i_val < i_lo ? i_lo : i_val;
    o_clamped = (i_val > i_hi) || (i_val < i_lo);
  end
endmodule

// File: rtl/pi_duty_controller.sv
// pi_duty_controller: PI duty regulator (in: clk rst enable sample_tick setpoint feedback kp ki; out: duty_ratio duty_valid busy saturated overrun)
module pi_duty_controller
  import pi_duty_controller_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     sample_tick,
  input  logic signed [DUTY_W-1:0] setpoint,
  input  logic signed [DUTY_W-1:0] feedback,
  input  logic        [11:0]       kp,
  input  logic        [11:0]       ki,
  output logic signed [DUTY_W-1:0] duty_ratio,
  output logic                     duty_valid,
  output logic                     busy,
  output logic                     saturated,
  output logic                     overrun
);
  localparam logic signed [ACC_W-1:0] INT_HI = ACC_W'(OUT_MAX <<< FRAC_BITS);
  localparam logic signed [ACC_W-1:0] INT_LO = ACC_W'(OUT_MIN <<< FRAC_BITS);
  localparam logic signed [ACC_W-1:0] DUTY_HI = ACC_W'(OUT_MAX);
  localparam logic signed [ACC_W-1:0] DUTY_LO = ACC_W'(OUT_MIN);
  logic        [2:0]       r_state;
  logic        [11:0]      r_kp, r_ki;
  logic signed [12:0]      r_err;
  logic signed [25:0]      r_p;
  logic signed [ACC_W-1:0] r_integ, r_sum;
  logic signed [DUTY_W-1:0] r_duty;
  logic                    r_valid, r_sat, r_overrun;
  logic        [11:0]      w_gain;
  logic signed [25:0]      w_prod;
  logic signed [ACC_W-1:0] w_inext, w_integ, w_sum_next, w_out;
  logic                    w_int_clamped, w_out_clamped;
  always_comb begin
    w_gain = r_state == S_MUL_P ? r_kp : r_ki;
    w_prod = $signed({1'b0, w_gain}) * r_err;
    w_inext = r_integ + ACC_W'(w_prod);
    w_sum_next = (ACC_W'(r_p) + r_integ) >>> FRAC_BITS;
  end
  pi_duty_controller_sat_clamp #(.W(ACC_W)) u_int_clamp (
    .i_val(w_inext), .i_lo(INT_LO), .i_hi(INT_HI), .o_val(w_integ), .o_clamped(w_int_clamped)
  );
  pi_duty_controller_sat_clamp #(.W(ACC_W)) u_out_clamp (
    .i_val(r_sum), .i_lo(DUTY_LO), .i_hi(DUTY_HI), .o_val(w_out), .o_clamped(w_out_clamped)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_kp <= '0;
      r_ki <= '0;
      r_err <= '0;
      r_p <= '0;
      r_integ <= '0;
      r_sum <= '0;
      r_duty <= '0;
      r_valid <= 1'b0;
      r_sat <= 1'b0;
      r_overrun <= 1'b0;
    end else if (!enable) begin
      r_state <= S_IDLE;
      r_integ <= '0;
      r_duty <= '0;
      r_valid <= 1'b0;
      r_sat <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state <= r_state == S_IDLE ? (sample_tick ? S_CAPTURE : S_IDLE) :
                 r_state == S_SAT ? S_IDLE : r_state + 3'd1;
      r_valid <= r_state == S_SAT;
      if (sample_tick && r_state != S_IDLE) r_overrun <= 1'b1;
      if (r_state == S_CAPTURE) begin
        r_kp <= kp;
        r_ki <= ki;
        r_err <= $signed({setpoint[DUTY_W-1], setpoint}) - $signed({feedback[DUTY_W-1], feedback});
      end
      if (r_state == S_MUL_P) r_p <= w_prod;
      if (r_state == S_MUL_I) r_integ <= w_integ;
      if (r_state == S_SUM) r_sum <= w_sum_next;
      if (r_state == S_SAT) begin
        r_duty <= DUTY_W'(w_out);
        r_sat <= w_out_clamped;
      end
    end
  end
  always_comb begin
    duty_ratio = r_duty;
    duty_valid = r_valid;
    busy = r_state != S_IDLE;
    saturated = r_sat;
    overrun = r_overrun;
  end
endmodule
